// File: rtl/logic_axi4_stream_packet_arbiter_pkg.sv
// Shared types and helpers for the packet-level AXI4-Stream arbiter.
package logic_axi4_stream_packet_arbiter_pkg;

  typedef enum logic {
    StIdle,
    StLocked
  } state_t;

  // Width of the grant index; a single requester still gets a 1-bit index.
  function automatic int unsigned grant_width(int unsigned inputs);
    return (inputs > 1) ? $clog2(inputs) : 1;
  endfunction

endpackage

// File: rtl/logic_axi4_stream_packet_arbiter_if.sv
// AXI4-Stream bundle with LANES parallel lanes (INPUTS lanes on rx, one lane on tx).
interface logic_axi4_stream_packet_arbiter_if #(
  parameter int unsigned LANES       = 1,
  parameter int unsigned TDATA_BYTES = 4,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 1
);
  logic [LANES-1:0]                    tvalid;
  logic [LANES-1:0]                    tready;
  logic [LANES-1:0]                    tlast;
  logic [LANES-1:0][TDATA_BYTES*8-1:0] tdata;
  logic [LANES-1:0][TDATA_BYTES-1:0]   tstrb;
  logic [LANES-1:0][TDATA_BYTES-1:0]   tkeep;
  logic [LANES-1:0][TUSER_WIDTH-1:0]   tuser;
  logic [LANES-1:0][TDEST_WIDTH-1:0]   tdest;
  logic [LANES-1:0][TID_WIDTH-1:0]     tid;

  modport master (
    output tvalid, tlast, tdata, tstrb, tkeep, tuser, tdest, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tlast, tdata, tstrb, tkeep, tuser, tdest, tid,
    output tready
  );
endinterface

// File: rtl/logic_axi4_stream_packet_arbiter_rr.sv
// Combinational rotating priority encoder: first request at or after the pointer, wrapping.
module logic_axi4_stream_packet_arbiter_rr
  import logic_axi4_stream_packet_arbiter_pkg::*;
#(
  parameter  int unsigned INPUTS = 4,
  localparam int unsigned GW     = grant_width(INPUTS)
) (
  input  logic [INPUTS-1:0] req_i,
  input  logic [GW-1:0]     ptr_i,
  output logic [GW-1:0]     idx_o,
  output logic              found_o
);

  logic [GW-1:0] cand;

  // Walk from the farthest offset back to the pointer so the nearest request wins last.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < INPUTS; k++) begin
      cand = GW'((32'(ptr_i) + INPUTS - 1 - k) % INPUTS);
      if (req_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/logic_axi4_stream_packet_arbiter.sv
// Packet-level round-robin arbiter feeding one registered AXI4-Stream output stage.
module logic_axi4_stream_packet_arbiter
  import logic_axi4_stream_packet_arbiter_pkg::*;
#(
  parameter  int unsigned INPUTS      = 4,
  parameter  int unsigned TDATA_BYTES = 4,
  parameter  int unsigned TUSER_WIDTH = 1,
  parameter  int unsigned TDEST_WIDTH = 1,
  parameter  int unsigned TID_WIDTH   = 1,
  parameter  int unsigned USE_TLAST   = 1,
  parameter  int unsigned USE_TKEEP   = 1,
  parameter  int unsigned USE_TSTRB   = 1,
  localparam int unsigned GW          = grant_width(INPUTS)
) (
  input  logic                                aclk,
  input  logic                                areset_n,
  logic_axi4_stream_packet_arbiter_if.slave   rx,
  logic_axi4_stream_packet_arbiter_if.master  tx,
  output logic [GW-1:0]                       grant,
  output logic                                grant_valid
);

  localparam int unsigned DW = TDATA_BYTES * 8;

  state_t                 state_q, state_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [GW-1:0]          ptr_q, ptr_d;
  logic [GW-1:0]          rr_idx;
  logic                   rr_found;
  logic                   sel_ready, accept, last_beat;

  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [DW-1:0]          tdata_q, tdata_d;
  logic [TDATA_BYTES-1:0] tstrb_q, tstrb_d;
  logic [TDATA_BYTES-1:0] tkeep_q, tkeep_d;
  logic [TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;

  logic_axi4_stream_packet_arbiter_rr #(
    .INPUTS(INPUTS)
  ) u_rr (
    .req_i  (rx.tvalid),
    .ptr_i  (ptr_q),
    .idx_o  (rr_idx),
    .found_o(rr_found)
  );

  // Arbitration FSM, per-requester ready and round-robin pointer update.
  always_comb begin
    sel_ready = !tvalid_q || tx.tready[0];
    rx.tready = '0;
    accept    = 1'b0;
    last_beat = 1'b0;
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (rr_found) begin
          grant_d = rr_idx;
          state_d = StLocked;
        end
      end
      StLocked: begin
        rx.tready[grant_q] = sel_ready;
        accept             = rx.tvalid[grant_q] && sel_ready;
        last_beat          = (USE_TLAST == 0) || rx.tlast[grant_q];
        if (accept && last_beat) begin
          state_d = StIdle;
          ptr_d   = (grant_q == GW'(INPUTS - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output stage: load on accept, drain on tready, otherwise hold everything stable.
  always_comb begin
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    tstrb_d  = tstrb_q;
    tkeep_d  = tkeep_q;
    tuser_d  = tuser_q;
    tdest_d  = tdest_q;
    tid_d    = tid_q;
    if (accept) begin
      tvalid_d = 1'b1;
      tlast_d  = last_beat;
      tdata_d  = rx.tdata[grant_q];
      tstrb_d  = (USE_TSTRB != 0) ? rx.tstrb[grant_q] : '1;
      tkeep_d  = (USE_TKEEP != 0) ? rx.tkeep[grant_q] : '1;
      tuser_d  = rx.tuser[grant_q];
      tdest_d  = rx.tdest[grant_q];
      tid_d    = rx.tid[grant_q];
    end else if (tx.tready[0]) begin
      tvalid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      ptr_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tkeep_q  <= '0;
      tuser_q  <= '0;
      tdest_q  <= '0;
      tid_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      tstrb_q  <= tstrb_d;
      tkeep_q  <= tkeep_d;
      tuser_q  <= tuser_d;
      tdest_q  <= tdest_d;
      tid_q    <= tid_d;
    end
  end

  assign tx.tvalid[0] = tvalid_q;
  assign tx.tlast[0]  = tlast_q;
  assign tx.tdata[0]  = tdata_q;
  assign tx.tstrb[0]  = tstrb_q;
  assign tx.tkeep[0]  = tkeep_q;
  assign tx.tuser[0]  = tuser_q;
  assign tx.tdest[0]  = tdest_q;
  assign tx.tid[0]    = tid_q;
  assign grant        = grant_q;
  assign grant_valid  = (state_q == StLocked);

endmodule
